// File: rtl/alu_pkg.sv
// Shared encodings for the Toy-ALU datapath: operation codes, control
// states and small helpers that turn an opcode into adder set-up values.
package alu_pkg;

    // Operation encoding on the 2-bit op bus.
    localparam logic [1:0] OP_ADD = 2'b00;  // a + b
    localparam logic [1:0] OP_SUB = 2'b01;  // a - b
    localparam logic [1:0] OP_ADC = 2'b10;  // a + b + cin
    localparam logic [1:0] OP_SBB = 2'b11;  // a - b - cin

    // Control states of the sequential adder.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Subtracting ops add the inverted B operand; both have op[0] set.
    function automatic logic op_is_sub(input logic [1:0] op);
        return op[0];
    endfunction

    // Carry seeded into chunk 0. Subtraction is a + ~b + 1, and a borrow-in
    // removes that +1, so SBB seeds the inverse of cin.
    function automatic logic seed_carry(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            OP_ADC:  c = cin;
            default: c = ~cin;
        endcase
        return c;
    endfunction

endpackage : alu_pkg

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple slice: {co, s} = a + b + ci.
module chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Zero-extend every term to W+1 bits so the carry out lands in the top bit.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule : chunk_add

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit. An accepted operation is resolved CHUNK bits
// per clock, LSB chunk first, through a single chunk_add slice. The result and
// its status flags are registered and held until the consumer takes them.
module seq_chunk_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    // Reject geometries that cannot be split into whole chunks.
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  opa;        // A, shifted right one chunk per RUN cycle
    logic [WIDTH-1:0]  opb;        // effective B' (b or ~b), shifted likewise
    logic              a_msb;      // sign bits of A and B' for overflow
    logic              b_msb;
    logic              cy;         // carry between chunks
    logic [WIDTH-1:0]  res;        // partial result, filled from the top
    logic [WIDTH-1:0]  res_next;
    logic [CHUNK-1:0]  chunk_s;
    logic              chunk_co;
    logic              accept;
    logic              last_chunk;
    logic              retire;

    assign in_ready   = (state == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (state == ST_RUN) && (cnt == LAST);
    assign retire     = (state == ST_DONE) && out_valid && out_ready;

    // The low chunk of each shifted operand is always the one being resolved.
    chunk_add #(.W(CHUNK)) u_chunk (
        .a  (opa[CHUNK-1:0]),
        .b  (opb[CHUNK-1:0]),
        .ci (cy),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Shift the new chunk in at the top; after NCHUNK shifts chunk 0 sits at the LSB.
    always_comb begin
        res_next = (res >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)     state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
            ST_DONE: if (retire)     state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset overrides any transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Operand and partial-result datapath.
    always_ff @(posedge clk) begin
        // NOTE: these registers have no reset; each is fully reloaded or rebuilt before it is observed.
        if (accept) begin
            opa   <= a;
            opb   <= op_is_sub(op) ? ~b : b;
            a_msb <= a[WIDTH-1];
            b_msb <= op_is_sub(op) ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (state == ST_RUN) begin
            opa <= opa >> CHUNK;
            opb <= opb >> CHUNK;
            res <= res_next;
        end
    end

    // Chunk counter, inter-chunk carry and the visible result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            cy        <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
                cy  <= seed_carry(op, cin);
            end else if (state == ST_RUN) begin
                cnt <= cnt + CW'(1);
                cy  <= chunk_co;
            end

            if (last_chunk) begin
                sum       <= res_next;
                carry     <= chunk_co;
                overflow  <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                zero      <= (res_next == '0);
                out_valid <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : seq_chunk_adder

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: four instances (CHUNK = 8, 1, 4, 32) receive the same
// operations in lock-step; expected results go through a scoreboard queue.
module tb_seq_chunk_adder;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int NI    = 4;
    localparam int CHUNKS [NI] = '{8, 1, 4, 32};
    localparam int LIMIT = 64;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             overflow;
        logic             zero;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             cin = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;

    logic             in_ready_w  [NI];
    logic             out_valid_w [NI];
    logic             carry_w     [NI];
    logic             overflow_w  [NI];
    logic             zero_w      [NI];
    logic [WIDTH-1:0] sum_w       [NI];

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNKS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .op        (op),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .sum       (sum_w[g]),
            .carry     (carry_w[g]),
            .overflow  (overflow_w[g]),
            .zero      (zero_w[g])
        );
    end

    // Reference model over the full width.
    function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic ci);
        exp_t           m;
        logic [WIDTH-1:0] yy;
        logic           c0;
        logic [WIDTH:0] r;
        yy = (o == OP_SUB || o == OP_SBB) ? ~y : y;
        case (o)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            OP_ADC:  c0 = ci;
            default: c0 = ~ci;
        endcase
        r = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
        m.sum      = r[WIDTH-1:0];
        m.carry    = r[WIDTH];
        m.overflow = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        m.zero     = (r[WIDTH-1:0] == '0);
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Handshake the result away and confirm every instance is back in IDLE.
    task automatic do_release(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (out_valid_w[i] !== 1'b0) begin
                fails++;
                $display("FAIL %s[c%0d] out_valid after release: got %b, want 0", tag, CHUNKS[i], out_valid_w[i]);
            end
            tests++;
            if (in_ready_w[i] !== 1'b1) begin
                fails++;
                $display("FAIL %s[c%0d] in_ready after release: got %b, want 1", tag, CHUNKS[i], in_ready_w[i]);
            end
        end
    endtask

    // Issue one operation to all instances, then compare each result with the scoreboard.
    task automatic run_op(input string tag, input exp_t e, input logic [1:0] o,
                          input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input bit release_after);
        int   lat  [NI];
        bit   seen [NI];
        bit   done;
        exp_t want;
        sb.push_back(e);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (in_ready_w[i] !== 1'b1) begin
                fails++;
                $display("FAIL %s[c%0d] in_ready before issue: got %b, want 1", tag, CHUNKS[i], in_ready_w[i]);
            end
        end
        op = o; a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op  = 2'($urandom);
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        for (int i = 0; i < NI; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 0;
        end
        for (int n = 0; n <= LIMIT; n++) begin
            done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && out_valid_w[i] === 1'b1) begin
                    seen[i] = 1'b1;
                    lat[i]  = n;
                end
                done = done & seen[i];
            end
            if (done) break;
            @(negedge clk);
        end
        want = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (!seen[i]) begin
                fails++;
                $display("FAIL %s[c%0d] out_valid timeout: got 0, want 1 within %0d cycles", tag, CHUNKS[i], LIMIT);
            end else begin
                tests++;
                if (lat[i] != WIDTH / CHUNKS[i]) begin
                    fails++;
                    $display("FAIL %s[c%0d] latency: got %0d, want %0d", tag, CHUNKS[i], lat[i], WIDTH / CHUNKS[i]);
                end
                tests++;
                if (sum_w[i] !== want.sum) begin
                    fails++;
                    $display("FAIL %s[c%0d] sum: got %h, want %h", tag, CHUNKS[i], sum_w[i], want.sum);
                end
                tests++;
                if (carry_w[i] !== want.carry) begin
                    fails++;
                    $display("FAIL %s[c%0d] carry: got %b, want %b", tag, CHUNKS[i], carry_w[i], want.carry);
                end
                tests++;
                if (overflow_w[i] !== want.overflow) begin
                    fails++;
                    $display("FAIL %s[c%0d] overflow: got %b, want %b", tag, CHUNKS[i], overflow_w[i], want.overflow);
                end
                tests++;
                if (zero_w[i] !== want.zero) begin
                    fails++;
                    $display("FAIL %s[c%0d] zero: got %b, want %b", tag, CHUNKS[i], zero_w[i], want.zero);
                end
            end
        end
        if (release_after) do_release(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({out_valid_w[i], carry_w[i], overflow_w[i], zero_w[i]} !== 4'b0000) begin
                fails++;
                $display("FAIL reset[c%0d] {out_valid,carry,overflow,zero}: got %b%b%b%b, want 0000",
                         CHUNKS[i], out_valid_w[i], carry_w[i], overflow_w[i], zero_w[i]);
            end
            tests++;
            if (sum_w[i] !== '0) begin
                fails++;
                $display("FAIL reset[c%0d] sum: got %h, want 0", CHUNKS[i], sum_w[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (in_ready_w[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset[c%0d] in_ready after release: got %b, want 1", CHUNKS[i], in_ready_w[i]);
            end
        end
    endtask

    task automatic test_directed();
        run_op("add_wrap",  '{32'h0000_0000, 1'b1, 1'b0, 1'b1}, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        run_op("add_ovf",   '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        run_op("sub_neg",   '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, OP_SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        run_op("sub_pos",   '{32'h0000_0002, 1'b1, 1'b0, 1'b0}, OP_SUB, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        run_op("adc_prop",  '{32'h0000_0100, 1'b0, 1'b0, 1'b0}, OP_ADC, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b1);
        run_op("sbb_prop",  '{32'h0000_00FF, 1'b1, 1'b0, 1'b0}, OP_SBB, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b1);
        run_op("sub_ovf",   '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        run_op("add_nocin", '{32'h0000_0002, 1'b0, 1'b0, 1'b0}, OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1);
        run_op("sub_zero",  '{32'h0000_0000, 1'b1, 1'b0, 1'b1}, OP_SUB, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1);
        run_op("sbb_bin",   '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}, OP_SBB, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
        run_op("sbb_nobin", '{32'h0000_0000, 1'b1, 1'b0, 1'b1}, OP_SBB, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1);
    endtask

    task automatic test_back_pressure();
        exp_t hold_e;
        hold_e = '{32'h2345_6789, 1'b0, 1'b0, 1'b0};
        run_op("bp_hold", hold_e, OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                tests++;
                if (out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0) begin
                    fails++;
                    $display("FAIL bp[c%0d] cycle %0d out_valid/in_ready: got %b/%b, want 1/0",
                             CHUNKS[i], k, out_valid_w[i], in_ready_w[i]);
                end
                tests++;
                if ({sum_w[i], carry_w[i], overflow_w[i], zero_w[i]} !== hold_e) begin
                    fails++;
                    $display("FAIL bp[c%0d] cycle %0d held result: got %h/%b%b%b, want %h/%b%b%b",
                             CHUNKS[i], k, sum_w[i], carry_w[i], overflow_w[i], zero_w[i],
                             hold_e.sum, hold_e.carry, hold_e.overflow, hold_e.zero);
                end
            end
        end
        in_valid = 1'b0;
        do_release("bp_release");
        run_op("bp_next", '{32'h0000_0003, 1'b0, 1'b0, 1'b0}, OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        run_op("pre_rst", '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        @(negedge clk);
        op = OP_ADD; a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
                fails++;
                $display("FAIL rst_run[c%0d] out_valid/in_ready: got %b/%b, want 0/1",
                         CHUNKS[i], out_valid_w[i], in_ready_w[i]);
            end
            tests++;
            if (sum_w[i] !== '0) begin
                fails++;
                $display("FAIL rst_run[c%0d] sum: got %h, want 0", CHUNKS[i], sum_w[i]);
            end
        end
        rst_n = 1'b1;
        run_op("post_rst", '{32'h0000_0002, 1'b1, 1'b0, 1'b0}, OP_SUB, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [1:0]       o;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             c;
        for (int n = 0; n < 1000; n++) begin
            o = 2'($urandom);
            x = pick_operand();
            y = pick_operand();
            c = 1'($urandom);
            run_op("rand", model(o, x, y, c), o, x, y, c, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_chunk_adder
